// File: rtl/tmr0_wdt_ctl_pkg.sv
// Shared constants for the Timer0 / watchdog control block: OPTION register
// field positions, prescaler width and a low-bit mask helper.
package tmr0_wdt_ctl_pkg;

  localparam int unsigned OPT_T0CS   = 5;
  localparam int unsigned OPT_T0SE   = 4;
  localparam int unsigned OPT_PSA    = 3;
  localparam int unsigned OPT_PS_MSB = 2;
  localparam int unsigned OPT_PS_LSB = 0;

  localparam int unsigned PS_W  = OPT_PS_MSB - OPT_PS_LSB + 1;
  localparam int unsigned PRE_W = 8;

  // Mask with the low nbits bits set (nbits in 0..8).
  function automatic logic [PRE_W-1:0] low_mask(input logic [3:0] nbits);
    return PRE_W'((9'd1 << nbits) - 9'd1);
  endfunction

endpackage

// File: rtl/tmr0_wdt_ctl_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop, giving a
// one-cycle tick on the selected edge of the synchronized level.
module tmr0_wdt_ctl_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic fall,
  output logic tick_c
);

  logic s1;
  logic s2;
  logic hist;

  // Synchronizer chain and edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign tick_c = fall ? (hist & ~s2) : (s2 & ~hist);

endmodule

// File: rtl/tmr0_wdt_ctl.sv
// Timer0 clock source, shared 8-bit prescaler and watchdog timer for the
// PIC16F54 core. Produces the registered tmr0_inc / wdtmr pulses and the
// STATUS TO bit.
module tmr0_wdt_ctl
  import tmr0_wdt_ctl_pkg::*;
#(
  parameter int unsigned WDT_BASE = 18000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] option,
  input  logic       t0cki,
  input  logic       tmr0_wr,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       wdt_en,
  output logic       tmr0_inc,
  output logic       wdtmr,
  output logic       to_n
);

  localparam int unsigned CNT_W = (WDT_BASE > 1) ? $clog2(WDT_BASE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDT_BASE - 1);

  logic            t0cs;
  logic            t0se;
  logic            psa;
  logic [PS_W-1:0] ps;
  logic            unused_opt;

  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] pre;
  logic             psa_q;
  logic             psa_vld;

  logic ext_tick_c;
  logic src_tick_c;
  logic wdt_clr_c;
  logic wdt_tick_c;
  logic psa_chg_c;
  logic pre_clr_c;
  logic pre_en_c;
  logic tmr_term_c;
  logic wdt_term_c;
  logic inc_c;
  logic wdt_c;

  assign t0cs       = option[OPT_T0CS];
  assign t0se       = option[OPT_T0SE];
  assign psa        = option[OPT_PSA];
  assign ps         = option[OPT_PS_MSB:OPT_PS_LSB];
  assign unused_opt = ^option[7:6];

  tmr0_wdt_ctl_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (t0cki),
    .fall   (t0se),
    .tick_c (ext_tick_c)
  );

  assign src_tick_c = t0cs ? ext_tick_c : 1'b1;
  assign wdt_clr_c  = clrwdt | sleep;
  assign wdt_tick_c = wdt_en & (cnt == CNT_LAST);

  // PSA history is only meaningful once it has been loaded after reset.
  assign psa_chg_c = psa_vld & (psa != psa_q);
  assign pre_clr_c = (tmr0_wr & ~psa) | (wdt_clr_c & psa) | psa_chg_c;
  assign pre_en_c  = psa ? wdt_tick_c : src_tick_c;

  // Timer0 divides by 2^(PS+1), watchdog by 2^PS (PS=0 gives an empty mask).
  assign tmr_term_c = &(pre | ~low_mask(4'(ps) + 4'd1));
  assign wdt_term_c = &(pre | ~low_mask(4'(ps)));

  // Prescaler assignment and terminal decode; any clear suppresses the pulse.
  always_comb begin
    inc_c = 1'b0;
    wdt_c = 1'b0;
    if (psa) begin
      inc_c = src_tick_c;
      wdt_c = wdt_tick_c & wdt_term_c & ~pre_clr_c & ~wdt_clr_c;
    end else begin
      inc_c = src_tick_c & tmr_term_c & ~pre_clr_c;
      wdt_c = wdt_tick_c & ~wdt_clr_c;
    end
  end

  // Watchdog base counter: 0..WDT_BASE-1, held at 0 when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!wdt_en || wdt_clr_c || wdt_tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Shared prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (pre_clr_c) begin
      pre <= '0;
    end else if (pre_en_c) begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Registered copy of PSA, first loaded on the edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psa_q   <= 1'b0;
      psa_vld <= 1'b0;
    end else begin
      psa_q   <= psa;
      psa_vld <= 1'b1;
    end
  end

  // Output pulses and TO bit; a set from CLRWDT/SLEEP beats a timeout clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr0_inc <= 1'b0;
      wdtmr    <= 1'b0;
      to_n     <= 1'b1;
    end else begin
      tmr0_inc <= inc_c;
      wdtmr    <= wdt_c;
      if (wdt_clr_c) begin
        to_n <= 1'b1;
      end else if (wdtmr) begin
        to_n <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tmr0_wdt_ctl.sv
// Scoreboard bench for tmr0_wdt_ctl: expected pulse cycles are queued as each
// scenario is set up and matched against observed tmr0_inc / wdtmr pulses.
module tb_tmr0_wdt_ctl;

  logic       clk;
  logic       rst;
  logic [7:0] option;
  logic       t0cki;
  logic       tmr0_wr;
  logic       clrwdt;
  logic       sleep;
  logic       wdt_en;
  logic       tmr0_inc;
  logic       wdtmr;
  logic       to_n;

  int total;
  int bad;
  int cyc;
  int exp_inc[$];
  int exp_wdt[$];
  bit mon_inc;

  tmr0_wdt_ctl #(.WDT_BASE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .option   (option),
    .t0cki    (t0cki),
    .tmr0_wr  (tmr0_wr),
    .clrwdt   (clrwdt),
    .sleep    (sleep),
    .wdt_en   (wdt_en),
    .tmr0_inc (tmr0_inc),
    .wdtmr    (wdtmr),
    .to_n     (to_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge number since reset release: after edge k, cyc == k.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one cycle and match any observed pulse against the scoreboard.
  task automatic step();
    @(negedge clk);
    if (mon_inc && tmr0_inc === 1'b1) begin
      if (exp_inc.size() == 0) chk("inc_extra", cyc, -1);
      else                     chk("inc_at", cyc, exp_inc.pop_front());
    end
    if (wdtmr === 1'b1) begin
      if (exp_wdt.size() == 0) chk("wdt_extra", cyc, -1);
      else                     chk("wdt_at", cyc, exp_wdt.pop_front());
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic end_scn();
    chk("inc_left", exp_inc.size(), 0);
    chk("wdt_left", exp_wdt.size(), 0);
    exp_inc.delete();
    exp_wdt.delete();
  endtask

  // Assert reset mid-cycle with random inputs, check outputs, then release.
  task automatic do_reset(input logic [7:0] opt, input logic en);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_inc", 32'(tmr0_inc), 0);
    chk("rst_async_ton", 32'(to_n), 1);
    repeat (6) begin
      option  = 8'($urandom);
      t0cki   = 1'($urandom);
      tmr0_wr = 1'($urandom);
      clrwdt  = 1'($urandom);
      sleep   = 1'($urandom);
      wdt_en  = 1'($urandom);
      @(negedge clk);
      chk("rst_inc", 32'(tmr0_inc), 0);
      chk("rst_wdt", 32'(wdtmr), 0);
      chk("rst_ton", 32'(to_n), 1);
    end
    option  = opt;
    wdt_en  = en;
    t0cki   = 1'b0;
    tmr0_wr = 1'b0;
    clrwdt  = 1'b0;
    sleep   = 1'b0;
    exp_inc.delete();
    exp_wdt.delete();
    rst = 1'b1;
  endtask

  // Square wave of period 10 on T0CKI; queue one pulse per selected edge.
  task automatic ext_run(input logic fall);
    for (int i = 0; i < 60; i++) begin
      logic v;
      v = ((cyc % 10) >= 5);
      if (fall ? (!v && t0cki) : (v && !t0cki)) exp_inc.push_back(cyc + 3);
      t0cki = v;
      step();
    end
    repeat (5) step();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; option = 8'h00; t0cki = 1'b0; tmr0_wr = 1'b0;
    clrwdt = 1'b0; sleep = 1'b0; wdt_en = 1'b0; mon_inc = 1'b1;

    // Internal clock, PSA=0 PS=0 then PS=2 on the free-running prescaler.
    do_reset(8'h00, 1'b0);
    for (int k = 2; k <= 40; k += 2) exp_inc.push_back(k);
    run_to(40);
    option = 8'h02;
    for (int k = 48; k <= 96; k += 8) exp_inc.push_back(k);
    run_to(96);
    end_scn();

    // Internal clock, prescaler on watchdog: every cycle.
    do_reset(8'h08, 1'b0);
    for (int k = 1; k <= 20; k++) exp_inc.push_back(k);
    run_to(20);
    end_scn();

    // External clock, rising then falling edge.
    do_reset(8'h28, 1'b0);
    ext_run(1'b0);
    end_scn();
    do_reset(8'h38, 1'b0);
    ext_run(1'b1);
    end_scn();

    // Watchdog timeout, TO behaviour and recovery with CLRWDT.
    mon_inc = 1'b0;
    do_reset(8'h08, 1'b1);
    exp_wdt.push_back(16); exp_wdt.push_back(32); exp_wdt.push_back(48);
    run_to(16);
    chk("ton_before", 32'(to_n), 1);
    step();
    chk("ton_after", 32'(to_n), 0);
    run_to(50);
    clrwdt = 1'b1;
    step();
    clrwdt = 1'b0;
    chk("ton_clr", 32'(to_n), 1);
    exp_wdt.push_back(67);
    run_to(70);
    end_scn();

    // Watchdog through prescaler 1:8 -> period 128.
    do_reset(8'h0B, 1'b1);
    exp_wdt.push_back(128); exp_wdt.push_back(256);
    run_to(260);
    end_scn();

    // Watchdog disabled: no timeout.
    do_reset(8'h08, 1'b0);
    run_to(1000);
    chk("ton_dis", 32'(to_n), 1);
    end_scn();

    // Periodic CLRWDT keeps the watchdog quiet.
    do_reset(8'h08, 1'b1);
    while (cyc < 200) begin
      clrwdt = ((cyc % 10) == 0);
      step();
    end
    clrwdt = 1'b0;
    chk("ton_kick", 32'(to_n), 1);
    end_scn();

    // CLRWDT exactly at terminal count suppresses the timeout.
    do_reset(8'h08, 1'b1);
    run_to(15);
    clrwdt = 1'b1;
    step();
    clrwdt = 1'b0;
    exp_wdt.push_back(32);
    run_to(20);
    chk("ton_term", 32'(to_n), 1);
    run_to(34);
    end_scn();

    // SLEEP at terminal count with PSA=0 also restarts the base counter.
    do_reset(8'h00, 1'b1);
    exp_wdt.push_back(16);
    run_to(31);
    sleep = 1'b1;
    step();
    sleep = 1'b0;
    exp_wdt.push_back(48);
    run_to(50);
    end_scn();

    // TMR0 writes clear the 1:256 prescaler, including at terminal count.
    mon_inc = 1'b1;
    do_reset(8'h07, 1'b0);
    exp_inc.push_back(256);
    run_to(356);
    tmr0_wr = 1'b1;
    step();
    tmr0_wr = 1'b0;
    exp_inc.push_back(613);
    run_to(868);
    tmr0_wr = 1'b1;
    step();
    tmr0_wr = 1'b0;
    exp_inc.push_back(1125);
    run_to(1130);
    end_scn();

    // PSA toggled mid-count clears the prescaler.
    do_reset(8'h01, 1'b0);
    exp_inc.push_back(4); exp_inc.push_back(8);
    run_to(10);
    option = 8'h09;
    exp_inc.push_back(11);
    step();
    option = 8'h01;
    exp_inc.push_back(16); exp_inc.push_back(20); exp_inc.push_back(24);
    run_to(24);
    end_scn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmr0_wdt_ctl.md
# tmr0_wdt_ctl

- Timer0 clock-source, shared-prescaler and watchdog block for the PIC16F54 core.
- Consumes the core's `option_out`, `SLEEP` and `CLRWDT` decode and TMR0-write strobe.
- Drives the core's `tmr0_inc` and `wdtmr` inputs, plus the STATUS TO bit.
- Sits beside the core at top level and is the producer end of the timer/watchdog interface.

## Interface
- `WDT_BASE`, default 18000: watchdog base period in `clk` cycles, ≥2; counter width is `$clog2(WDT_BASE)`.
- `clk` in 1: single clock, one instruction cycle per edge.
- `rst` in 1: reset, asynchronous, active-low.
- `option` in 8: OPTION register; [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS.
- `t0cki` in 1: external T0CKI pin, asynchronous.
- `tmr0_wr` in 1: core writes TMR0 this cycle.
- `clrwdt` in 1: CLRWDT executed this cycle.
- `sleep` in 1: SLEEP executed this cycle.
- `wdt_en` in 1: watchdog enable (configuration fuse), static.
- `tmr0_inc` out 1: one-cycle pulse; TMR0 increments.
- `wdtmr` out 1: one-cycle pulse; watchdog timeout.
- `to_n` out 1: STATUS TO bit.

## Operation
- **Sync path:** `t0cki` passes through a 2-flop synchronizer plus one history flop.
  - With T0SE=0, `ext_tick` = rising edge of the synchronized signal.
  - With T0SE=1, `ext_tick` = falling edge.
- **Source tick:** `src_tick` = T0CS ? `ext_tick` : 1 (every cycle).
- **Watchdog base counter:** counts 0..WDT_BASE-1 and wraps. `wdt_tick` is asserted in the cycle the count equals WDT_BASE-1. When `wdt_en`=0 the counter is held at 0 and there is no `wdt_tick`.
- **8-bit prescaler `pre`:** shared by Timer0 and the watchdog.
  - PSA=0: `pre` counts `src_tick`. `tmr0_inc` fires when `src_tick` is asserted and `pre[PS:0]` is all ones, giving rate 1:2^(PS+1). `wdtmr` = `wdt_tick`.
  - PSA=1: `pre` counts `wdt_tick`. `wdtmr` fires when `wdt_tick` is asserted and `pre[PS-1:0]` is all ones (PS=0 fires on every tick), giving rate 1:2^PS. `tmr0_inc` = `src_tick`.
- **Prescaler clear:** `pre` clears to 0 on any of:
  - `tmr0_wr` while PSA=0;
  - `clrwdt` or `sleep` while PSA=1;
  - any change of PSA (compared against a registered copy).
- **Watchdog clear:** `clrwdt` or `sleep` clears the base counter regardless of PSA.
- **Clear priority:** a clear wins over a tick in the same cycle; no output pulse is produced that cycle. This applies to `clrwdt` coinciding with terminal count, and to `tmr0_wr` coinciding with prescaler terminal count.
- **TO bit:** `to_n` clears on a `wdtmr` pulse and sets on `clrwdt` or `sleep`. If a set and a clear coincide, the set wins (the timeout was suppressed anyway).
- **PS changes:** a PS change without a PSA change does not clear `pre`. The new terminal mask applies from the next cycle.

## Timing
- **Reset values:** `tmr0_inc`=0, `wdtmr`=0, `to_n`=1, `pre`=0, base counter=0, sync flops=0, PSA history = `option[3]` sampled after release.
- **Registered outputs:** `tmr0_inc` and `wdtmr` are registered, one cycle after the combinational condition.
- **Internal source, PSA=1:** `tmr0_inc` is high continuously from the first edge after reset release.
- **Internal source, PSA=0, PS=n:** first pulse after edge 2^(n+1), then every 2^(n+1) cycles.
- **External source:** a pin edge set up before edge k produces `tmr0_inc` after edge k+2 (3-cycle latency). The pin must hold each level for at least 2 cycles; narrower pulses may be missed.
- **Watchdog, PSA=0:** first `wdtmr` after edge WDT_BASE, then every WDT_BASE cycles.
- **Watchdog, PSA=1, PS=n:** period is WDT_BASE·2^n.
- **Mid-operation reset:** reset asserted mid-count aborts all counts immediately (asynchronously). No pulse is produced on release.

## Structure
- **Shared package:** OPTION bit-index constants (T0CS=5, T0SE=4, PSA=3, PS_MSB=2, PS_LSB=0).
- **Sub-module `sync_edge`:** 2-flop synchronizer plus edge detector with an edge-polarity select; outputs a one-cycle tick.
- **Top module:** base counter, prescaler, mask/terminal logic, output registers and `to_n`.

## Test plan
All watchdog scenarios use WDT_BASE=16.
- **Reset:** hold `rst`=0 with random inputs → `tmr0_inc`=0, `wdtmr`=0, `to_n`=1 throughout; release → no spurious pulse.
- **Internal prescale:**
  - `option`=8'h00 → `tmr0_inc` at edges 2, 4, 6, …
  - switch to 8'h02 → pulses every 8 cycles.
  - `option`=8'h08 → `tmr0_inc` high every cycle.
- **External source:** `option`=8'h28, `t0cki` square wave with period 10 cycles → one `tmr0_inc` per rising edge, 3 edges after the pin rises. With 8'h38 → pulses track falling edges.
- **Watchdog timeout:** `wdt_en`=1.
  - `option`=8'h08 → `wdtmr` after edge 16, `to_n`=0 the next cycle.
  - 8'h0B → period 128.
  - `wdt_en`=0 → no pulse in 1000 cycles.
- **CLRWDT:**
  - `clrwdt` every 10 cycles → no `wdtmr`, `to_n` stays 1.
  - `clrwdt` exactly at terminal count → no pulse.
  - after a timeout, `clrwdt` → `to_n` returns to 1.
- **TMR0 write:** `option`=8'h07, `tmr0_wr` 100 cycles after the previous pulse → next `tmr0_inc` exactly 256 cycles after the write. Toggle PSA mid-count → prescaler clears.
